// File: rtl/adder_tree_accum_ctrl.sv
// rtl/adder_tree_accum_ctrl.sv - beat-streaming reduction sequencer around an adder tree
// Optional feature: define ADDER_TREE_ACCUM_SAT_EN to saturate the accumulator on carry
// out instead of wrapping.

module adder_tree #(
  parameter int INPUTS_NUM  = 8,
  parameter int IDATA_WIDTH = 8,
  parameter int TREE_WIDTH  = IDATA_WIDTH + $clog2(INPUTS_NUM)
) (
  input  logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] idata,
  output logic [TREE_WIDTH-1:0]                  osum
);

  // Unsigned sum of all elements; TREE_WIDTH leaves room for every carry.
  always_comb begin
    osum = '0;
    for (int i = 0; i < INPUTS_NUM; i++) begin
      osum = osum + TREE_WIDTH'(idata[i]);
    end
  end

endmodule

module adder_tree_accum_ctrl #(
  parameter int INPUTS_NUM  = 8,
  parameter int IDATA_WIDTH = 8,
  parameter int BEATS_W     = 8,
  parameter int ACC_WIDTH   = IDATA_WIDTH + $clog2(INPUTS_NUM) + BEATS_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clear,
  input  logic                                   start,
  input  logic [BEATS_W-1:0]                     num_beats,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] idata,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ACC_WIDTH-1:0]                   odata,
  output logic                                   busy,
  output logic                                   overflow
);

  localparam int TREE_WIDTH = IDATA_WIDTH + $clog2(INPUTS_NUM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [BEATS_W-1:0]     r_count;
  logic                   r_ovf;
  logic [TREE_WIDTH-1:0]  w_tree_sum;
  logic [ACC_WIDTH:0]     w_acc_sum;
  logic                   w_carry;
  logic                   w_beat;
  logic                   w_start;

  adder_tree #(
    .INPUTS_NUM  (INPUTS_NUM),
    .IDATA_WIDTH (IDATA_WIDTH),
    .TREE_WIDTH  (TREE_WIDTH)
  ) u_tree (
    .idata (idata),
    .osum  (w_tree_sum)
  );

  // One extra bit on the sum exposes the carry out of ACC_WIDTH.
  assign w_acc_sum = {1'b0, r_acc} + (ACC_WIDTH + 1)'(w_tree_sum);
  assign w_carry   = w_acc_sum[ACC_WIDTH];
  assign w_beat    = (r_state == S_ACCUM) && in_valid && !clear;
  assign w_start   = (r_state == S_IDLE) && start && !clear;

  assign odata    = r_acc;
  assign overflow = r_ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; handshake outputs decode only the registered state.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (num_beats != '0) ? S_ACCUM : S_DONE;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (r_count == BEATS_W'(1))) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Accumulator, remaining-beat counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_start) begin
      r_acc   <= '0;
      r_count <= num_beats;
      r_ovf   <= 1'b0;
    end else if (w_beat) begin
      r_count <= r_count - BEATS_W'(1);
      r_ovf   <= r_ovf | w_carry;
`ifdef ADDER_TREE_ACCUM_SAT_EN
      r_acc   <= w_carry ? {ACC_WIDTH{1'b1}} : w_acc_sum[ACC_WIDTH-1:0];
`else
      r_acc   <= w_acc_sum[ACC_WIDTH-1:0];
`endif
    end
  end

endmodule
